// File: rtl/adc_fill_num_checker_if.sv
// Fill-header handshake bundle: valid/ready plus 24-bit fill number.
// master drives valid and fill number; slave drives ready.
interface adc_fill_num_checker_if;
  logic        hdr_valid;
  logic [23:0] hdr_fill_num;
  logic        hdr_ready;

  modport master (
    output hdr_valid,
    output hdr_fill_num,
    input  hdr_ready
  );

  modport slave (
    input  hdr_valid,
    input  hdr_fill_num,
    output hdr_ready
  );
endinterface

// File: rtl/adc_fill_num_checker.sv
// Checks header fill numbers against a locally tracked expected value.
// Ports: clk/rst, init + initial_fill_num arm, hdr (slave handshake),
// match/mismatch pulses, gap flag, sticky/counted error status, armed.
module adc_fill_num_checker #(
  parameter bit RESYNC = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 initial_fill_num,
  input  logic                        init,
  adc_fill_num_checker_if.slave       hdr,
  output logic [23:0]                 expected_fill_num,
  output logic                        fill_ok,
  output logic                        fill_err,
  output logic                        err_gap,
  output logic                        err_sticky,
  output logic [23:0]                 last_bad_fill,
  output logic [15:0]                 err_count,
  output logic [31:0]                 hdr_count,
  output logic                        armed
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        accept;
  logic [23:0] diff;

  // init takes priority over a header arriving in the same cycle
  assign hdr.hdr_ready = (state == RUN) && !init;
  assign accept        = hdr.hdr_valid && hdr.hdr_ready;
  assign armed         = (state == RUN);

  // Forward distance modulo 2^24; the lower half-range counts as a gap
  assign diff = hdr.hdr_fill_num - expected_fill_num;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      expected_fill_num <= '0;
      fill_ok           <= 1'b0;
      fill_err          <= 1'b0;
      err_gap           <= 1'b0;
      err_sticky        <= 1'b0;
      last_bad_fill     <= '0;
      err_count         <= '0;
      hdr_count         <= '0;
    end else begin
      fill_ok  <= 1'b0;
      fill_err <= 1'b0;
      err_gap  <= 1'b0;
      if (init) begin
        state             <= RUN;
        expected_fill_num <= initial_fill_num;
        err_sticky        <= 1'b0;
        last_bad_fill     <= '0;
        err_count         <= '0;
        hdr_count         <= '0;
      end else if (accept) begin
        hdr_count <= hdr_count + 32'd1;
        if (diff == 24'd0) begin
          fill_ok           <= 1'b1;
          expected_fill_num <= expected_fill_num + 24'd1;
        end else begin
          fill_err      <= 1'b1;
          err_gap       <= !diff[23];
          err_sticky    <= 1'b1;
          last_bad_fill <= hdr.hdr_fill_num;
          if (err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
          if (RESYNC)
            expected_fill_num <= hdr.hdr_fill_num + 24'd1;
          else
            expected_fill_num <= expected_fill_num + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_fill_num_checker.sv
// Bench for adc_fill_num_checker: RESYNC=1 and RESYNC=0 instances
// driven in parallel, checked by vector table, hand sequences, model.
module tb_adc_fill_num_checker;

  localparam int M = 1 << 24;
  localparam int H = 1 << 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [23:0] initial_fill_num;

  logic [23:0] exp_o [2];
  logic        ok_o  [2];
  logic        err_o [2];
  logic        gap_o [2];
  logic        stk_o [2];
  logic [23:0] last_o[2];
  logic [15:0] ecnt_o[2];
  logic [31:0] hcnt_o[2];
  logic        arm_o [2];

  adc_fill_num_checker_if bus0 ();
  adc_fill_num_checker_if bus1 ();

  always #5 clk = ~clk;

  adc_fill_num_checker #(.RESYNC(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .initial_fill_num(initial_fill_num), .init(init),
    .hdr(bus0.slave),
    .expected_fill_num(exp_o[0]), .fill_ok(ok_o[0]),
    .fill_err(err_o[0]), .err_gap(gap_o[0]),
    .err_sticky(stk_o[0]), .last_bad_fill(last_o[0]),
    .err_count(ecnt_o[0]), .hdr_count(hcnt_o[0]),
    .armed(arm_o[0])
  );

  adc_fill_num_checker #(.RESYNC(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .initial_fill_num(initial_fill_num), .init(init),
    .hdr(bus1.slave),
    .expected_fill_num(exp_o[1]), .fill_ok(ok_o[1]),
    .fill_err(err_o[1]), .err_gap(gap_o[1]),
    .err_sticky(stk_o[1]), .last_bad_fill(last_o[1]),
    .err_count(ecnt_o[1]), .hdr_count(hcnt_o[1]),
    .armed(arm_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model, one slot per instance (0: resync, 1: advance)
  bit          m_arm [2];
  int          m_exp [2];
  bit          m_ok  [2];
  bit          m_err [2];
  bit          m_gap [2];
  bit          m_stk [2];
  int          m_last[2];
  int          m_ecnt[2];
  int unsigned m_hcnt[2];

  task automatic cmp(input string nm, input longint act,
                     input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [127:0] dut_vec(input int k);
    logic rdy;
    rdy = (k == 0) ? bus0.hdr_ready : bus1.hdr_ready;
    return {26'd0, rdy, exp_o[k], ok_o[k], err_o[k], gap_o[k],
            stk_o[k], last_o[k], ecnt_o[k], hcnt_o[k], arm_o[k]};
  endfunction

  function automatic logic [127:0] mdl_vec(input int k);
    logic rdy;
    rdy = m_arm[k] && !init;
    return {26'd0, rdy, m_exp[k][23:0], m_ok[k], m_err[k],
            m_gap[k], m_stk[k], m_last[k][23:0], m_ecnt[k][15:0],
            m_hcnt[k], m_arm[k]};
  endfunction

  task automatic model(input bit r, input bit in, input int iv,
                       input bit v, input int h);
    int d;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_arm[k] = 0; m_exp[k] = 0; m_ok[k] = 0; m_err[k] = 0;
        m_gap[k] = 0; m_stk[k] = 0; m_last[k] = 0;
        m_ecnt[k] = 0; m_hcnt[k] = 0;
      end else begin
        m_ok[k] = 0; m_err[k] = 0; m_gap[k] = 0;
        if (in) begin
          m_arm[k] = 1; m_exp[k] = iv; m_stk[k] = 0;
          m_last[k] = 0; m_ecnt[k] = 0; m_hcnt[k] = 0;
        end else if (m_arm[k] && v) begin
          m_hcnt[k]++;
          if (h == m_exp[k]) begin
            m_ok[k] = 1;
            m_exp[k] = (m_exp[k] + 1) % M;
          end else begin
            d = (h - m_exp[k] + M) % M;
            m_err[k] = 1;
            m_gap[k] = (d < H);
            m_stk[k] = 1;
            m_last[k] = h;
            if (m_ecnt[k] < 65535) m_ecnt[k]++;
            m_exp[k] = (k == 0) ? (h + 1) % M : (m_exp[k] + 1) % M;
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit in, input int iv,
                      input bit v, input int h, input bit chk);
    rst = r; init = in; initial_fill_num = iv[23:0];
    bus0.hdr_valid = v; bus0.hdr_fill_num = h[23:0];
    bus1.hdr_valid = v; bus1.hdr_fill_num = h[23:0];
    model(r, in, iv, v, h);
    @(posedge clk);
    #1;
    if (chk) begin
      cmp("model_resync", dut_vec(0), mdl_vec(0));
      cmp("model_advance", dut_vec(1), mdl_vec(1));
    end
  endtask

  typedef struct {
    bit r; bit in; int iv; bit v; int h;
    bit ok; bit err; bit gap; int ex; bit arm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int h;
    // RESYNC=1 instance expectations
    tbl.push_back('{1, 0,   0, 0,   0, 0, 0, 0,   0, 0});
    tbl.push_back('{0, 1, 100, 0,   0, 0, 0, 0, 100, 1});
    tbl.push_back('{0, 0,   0, 1, 100, 1, 0, 0, 101, 1});
    tbl.push_back('{0, 0,   0, 1, 101, 1, 0, 0, 102, 1});
    tbl.push_back('{0, 0,   0, 1, 102, 1, 0, 0, 103, 1});
    tbl.push_back('{0, 1, 100, 0,   0, 0, 0, 0, 100, 1});
    tbl.push_back('{0, 0,   0, 1, 100, 1, 0, 0, 101, 1});
    tbl.push_back('{0, 0,   0, 1, 103, 0, 1, 1, 104, 1});
    tbl.push_back('{0, 0,   0, 1, 104, 1, 0, 0, 105, 1});
    tbl.push_back('{0, 1,  50, 0,   0, 0, 0, 0,  50, 1});
    tbl.push_back('{0, 0,   0, 1,  49, 0, 1, 0,  50, 1});
    tbl.push_back('{0, 0,   0, 1,  50, 1, 0, 0,  51, 1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].in, tbl[i].iv, tbl[i].v, tbl[i].h, 1);
      cmp($sformatf("vec%0d", i),
          {ok_o[0], err_o[0], gap_o[0], exp_o[0], arm_o[0]},
          {tbl[i].ok, tbl[i].err, tbl[i].gap,
           tbl[i].ex[23:0], tbl[i].arm});
    end

    // gap scenario follow-up status on the resync instance
    step(0, 1, 100, 0, 0, 1);
    step(0, 0, 0, 1, 100, 1);
    step(0, 0, 0, 1, 103, 1);
    cmp("gap_last_bad", last_o[0], 103);
    cmp("gap_err_count", ecnt_o[0], 1);
    cmp("gap_sticky", stk_o[0], 1);

    // RESYNC=0: expected advances by one past a repeat
    step(0, 1, 50, 0, 0, 1);
    step(0, 0, 0, 1, 49, 1);
    cmp("adv_err", {err_o[1], gap_o[1]}, 2'b10);
    cmp("adv_exp", exp_o[1], 51);
    step(0, 0, 0, 1, 51, 1);
    cmp("adv_ok", ok_o[1], 1);

    // 24-bit wrap is silent
    step(0, 1, 24'hFFFFFE, 0, 0, 1);
    step(0, 0, 0, 1, 24'hFFFFFE, 1);
    cmp("wrap_ok0", ok_o[0], 1);
    step(0, 0, 0, 1, 24'hFFFFFF, 1);
    cmp("wrap_ok1", ok_o[0], 1);
    step(0, 0, 0, 1, 0, 1);
    cmp("wrap_ok2", {ok_o[0], err_o[0]}, 2'b10);
    cmp("wrap_exp", exp_o[0], 1);
    step(0, 1, 24'hFFFFFE, 0, 0, 1);
    step(0, 0, 0, 1, 5, 1);
    cmp("wrap_gap", {err_o[0], gap_o[0]}, 2'b11);

    // saturating error counter
    step(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 65537; i++) begin
      h = (m_exp[0] + 7) % M;
      if (h == m_exp[1]) h = (h + 1) % M;
      step(0, 0, 0, 1, h, i > 65530);
    end
    cmp("sat_count", ecnt_o[0], 16'hFFFF);
    step(0, 0, 0, 1, (m_exp[0] + 9) % M, 1);
    cmp("sat_hold", ecnt_o[0], 16'hFFFF);
    step(0, 1, 3, 0, 0, 1);
    cmp("sat_init_clr", {ecnt_o[0], stk_o[0]}, 17'd0);

    // valid before init stalls
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    cmp("pre_init_ready", bus0.hdr_ready, 0);
    cmp("pre_init_cnt", hcnt_o[0], 0);
    // init and valid together in RUN
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 9, 1, 9, 1);
    cmp("init_wins_cnt", hcnt_o[0], 0);
    cmp("init_wins_ok", ok_o[0], 0);
    // reset mid-handshake
    step(0, 0, 0, 1, 9, 1);
    step(1, 0, 0, 1, 10, 1);
    cmp("rst_mid", dut_vec(0), 128'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, in, v;
      int iv;
      r  = ($urandom_range(0, 199) == 0);
      in = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      iv = (($urandom_range(0, 3) == 0) ? (M - 3) : 0)
           + $urandom_range(0, 2);
      case ($urandom_range(0, 5))
        0, 1, 2: h = m_exp[$urandom_range(0, 1)];
        3:       h = (m_exp[0] + $urandom_range(1, 4)) % M;
        4:       h = (m_exp[0] - $urandom_range(1, 4) + M) % M;
        default: h = $urandom_range(0, M - 1);
      endcase
      step(r, in, iv, v, h, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
